// File: rtl/fifo_pkg.sv
// fifo_pkg: shared types and Gray-code helpers for the async FIFO read side.
// The helpers work on zero-extended words up to GRAY_MAX_W bits. Callers narrow
// the result with a size cast, so any pointer width up to GRAY_MAX_W can use them.
package fifo_pkg;

    localparam int GRAY_MAX_W = 32;

    // Occupancy of the 2-entry output buffer (head + skid).
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_state_t;

    // Binary to reflected Gray code.
    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] gray);
        logic [GRAY_MAX_W-1:0] bin;
        bin = gray;
        for (int i = 1; i < GRAY_MAX_W; i++) begin
            bin = bin ^ (gray >> i);
        end
        return bin;
    endfunction

endpackage

// File: rtl/fifo_out_skid.sv
// fifo_out_skid: 2-entry valid/ready output buffer for the FIFO read side.
// The head register drives m_data directly, the skid register catches the word
// fetched while the head is stalled, so the parent can fetch every cycle.
module fifo_out_skid
    import fifo_pkg::*;
#(
    parameter int DATASIZE = 8
) (
    input  logic                r_clk,
    input  logic                r_rst_n,
    input  logic                push,
    input  logic [DATASIZE-1:0] push_data,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [DATASIZE-1:0] m_data,
    output occ_state_t          occ
);

    logic [DATASIZE-1:0] skid;
    logic                pop;

    assign pop = m_valid & m_ready;

    // Occupancy FSM with registered m_valid; push is never asserted in OCC_TWO without pop.
    always_ff @(posedge r_clk or negedge r_rst_n) begin
        if (!r_rst_n) begin
            // NOTE: the data registers are reset as well, so m_data reads 0 straight out of reset.
            occ     <= OCC_EMPTY;
            m_valid <= 1'b0;
            m_data  <= '0;
            skid    <= '0;
        end else begin
            // NOTE: non-blocking assignments, so every branch sees the pre-edge head/skid values.
            case (occ)
                OCC_EMPTY: begin
                    if (push) begin
                        m_data  <= push_data;
                        m_valid <= 1'b1;
                        occ     <= OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (push && pop) begin
                        m_data <= push_data;
                    end else if (push) begin
                        skid <= push_data;
                        occ  <= OCC_TWO;
                    end else if (pop) begin
                        m_valid <= 1'b0;
                        occ     <= OCC_EMPTY;
                    end
                end
                OCC_TWO: begin
                    if (pop) begin
                        m_data <= skid;
                        if (push) begin
                            skid <= push_data;
                        end else begin
                            occ <= OCC_ONE;
                        end
                    end
                end
                default: begin
                    m_valid <= 1'b0;
                    occ     <= OCC_EMPTY;
                end
            endcase
        end
    end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: read-side controller of the async FIFO (read clock domain).
// Owns the binary/Gray read pointer and the registered empty flag, addresses the
// memory and feeds its combinational read data into a first-word-fall-through
// output buffer.
// Optional feature: define FIFO_RD_LEVEL_EN to add the r_level output, the number
// of unread words still in memory (words already in the output buffer excluded).
module fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int DATASIZE = 8,
    parameter int ADDRSIZE = 4
) (
    input  logic                r_clk,
    input  logic                r_rst_n,
    input  logic [ADDRSIZE:0]   rq2_wptr,
    output logic [ADDRSIZE:0]   r_ptr,
    output logic [ADDRSIZE-1:0] r_addr,
    input  logic [DATASIZE-1:0] mem_rdata,
    output logic                r_empty,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [DATASIZE-1:0] m_data
`ifdef FIFO_RD_LEVEL_EN
    ,
    output logic [ADDRSIZE:0]   r_level
`endif
);

    localparam int PTR_W = ADDRSIZE + 1;

    logic [PTR_W-1:0] rbin;
    logic [PTR_W-1:0] rbin_next;
    logic [PTR_W-1:0] rgray_next;
    occ_state_t       occ;
    logic             pop;
    logic             fetch;

    // A word leaves memory whenever there is one and the buffer has (or is making) room.
    assign pop        = m_valid & m_ready;
    assign fetch      = ~r_empty & ((occ != OCC_TWO) | pop);
    assign rbin_next  = rbin + {{(PTR_W-1){1'b0}}, fetch};
    assign rgray_next = PTR_W'(bin2gray(GRAY_MAX_W'(rbin_next)));
    assign r_addr     = rbin[ADDRSIZE-1:0];

    // Pointer pair and empty flag; empty looks at the next pointer so it never lags a fetch.
    always_ff @(posedge r_clk or negedge r_rst_n) begin
        if (!r_rst_n) begin
            rbin    <= '0;
            r_ptr   <= '0;
            r_empty <= 1'b1;
        end else begin
            rbin    <= rbin_next;
            r_ptr   <= rgray_next;
            r_empty <= (rgray_next == rq2_wptr);
        end
    end

`ifdef FIFO_RD_LEVEL_EN
    logic [PTR_W-1:0] wbin_sync;

    assign wbin_sync = PTR_W'(gray2bin(GRAY_MAX_W'(rq2_wptr)));

    // Unread words left in memory, measured against the post-fetch read pointer.
    always_ff @(posedge r_clk or negedge r_rst_n) begin
        if (!r_rst_n) begin
            r_level <= '0;
        end else begin
            r_level <= wbin_sync - rbin_next;
        end
    end
`endif

    fifo_out_skid #(
        .DATASIZE (DATASIZE)
    ) u_out_skid (
        .r_clk     (r_clk),
        .r_rst_n   (r_rst_n),
        .push      (fetch),
        .push_data (mem_rdata),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .occ       (occ)
    );

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb_fifo_rd_ctrl: directed bench for fifo_rd_ctrl.
// Models the FIFO memory as an async-read array plus a write-side pointer whose
// Gray value reaches the DUT through two sync stages; the read pointer is synced
// back the same way to keep the writer from overrunning the memory.
module tb_fifo_rd_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int PW    = AW + 1;
    localparam int DEPTH = 1 << AW;

    logic          r_clk = 1'b0;
    logic          r_rst_n;
    logic [PW-1:0] rq2_wptr;
    logic [PW-1:0] r_ptr;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] mem_rdata;
    logic          r_empty;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
`ifdef FIFO_RD_LEVEL_EN
    logic [PW-1:0] r_level;
`endif

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wbin, wgray, sync1, wq1, wq2;
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] stall_data;
    logic [DW-1:0] exp_word;
    bit            stalled;
    bit            last_msb;
    int            checks = 0;
    int            errors = 0;
    int            pops = 0;
    int            msb_toggles = 0;

    assign mem_rdata = mem[r_addr];

    always #5 r_clk = ~r_clk;

    fifo_rd_ctrl #(
        .DATASIZE (DW),
        .ADDRSIZE (AW)
    ) dut (
        .r_clk     (r_clk),
        .r_rst_n   (r_rst_n),
        .rq2_wptr  (rq2_wptr),
        .r_ptr     (r_ptr),
        .r_addr    (r_addr),
        .mem_rdata (mem_rdata),
        .r_empty   (r_empty),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data)
`ifdef FIFO_RD_LEVEL_EN
        ,
        .r_level   (r_level)
`endif
    );

    function automatic logic [PW-1:0] to_gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Writer is full when its Gray pointer is the synced read pointer with the top two bits flipped.
    function automatic bit wr_full();
        return wgray == {~wq2[PW-1:PW-2], wq2[PW-3:0]};
    endfunction

    // Write one word into the memory model and queue it as expected output.
    task automatic wr(input logic [DW-1:0] d);
        mem[wbin[AW-1:0]] = d;
        wbin  = wbin + 1'b1;
        wgray = to_gray(wbin);
        exp_q.push_back(d);
    endtask

    // One read-clock cycle: shift the pointer syncs, check stall stability and popped words.
    task automatic cyc(input bit rdy);
        @(negedge r_clk);
        rq2_wptr = sync1;
        sync1    = wgray;
        wq2      = wq1;
        wq1      = r_ptr;
        if (r_ptr[PW-1] != last_msb) begin
            msb_toggles++;
            last_msb = r_ptr[PW-1];
        end
        if (stalled) begin
            check("stall_hold", 32'({m_valid, m_data}), 32'({1'b1, stall_data}));
        end
        m_ready = rdy;
        if (m_valid && rdy) begin
            if (exp_q.size() == 0) begin
                check("extra_word", 32'(m_data), 32'hFFFF_FFFF);
            end else begin
                exp_word = exp_q.pop_front();
                check("order", 32'(m_data), 32'(exp_word));
                pops++;
            end
        end
        stalled    = m_valid && !rdy;
        stall_data = m_data;
    endtask

    // Reset DUT and the bench-side write domain together.
    task automatic do_reset();
        r_rst_n     = 1'b0;
        m_ready     = 1'b0;
        wbin        = '0;
        wgray       = '0;
        sync1       = '0;
        rq2_wptr    = '0;
        wq1         = '0;
        wq2         = '0;
        stalled     = 1'b0;
        last_msb    = 1'b0;
        msb_toggles = 0;
        exp_q.delete();
        repeat (3) @(negedge r_clk);
        r_rst_n = 1'b1;
    endtask

    // Idle state held for 10 cycles: empty, no valid, pointer and address at 0.
    task automatic idle_check(input string tag);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0);
            check(tag, 32'({r_empty, m_valid, r_ptr, r_addr}), 32'({1'b1, 1'b0, 5'd0, 4'd0}));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int  p0;
        int  n_wr;
        bit  found;

        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        r_rst_n  = 1'b0;
        m_ready  = 1'b0;
        rq2_wptr = '0;
        do_reset();

        // 1: idle after reset
        idle_check("s1_idle");

        // 2: single word, fall-through latency, single pop
        do_reset();
        wr(8'hA5);
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            cyc(1'b1);
            if (!r_empty) found = 1'b1;
        end
        check("s2_empty_fall", 32'(found), 32'd1);
        check("s2_valid_lag", 32'(m_valid), 32'd0);
        cyc(1'b1);
        check("s2_head", 32'({m_valid, m_data}), 32'({1'b1, 8'hA5}));
        cyc(1'b1);
        check("s2_drained", 32'({r_empty, m_valid}), 32'({1'b1, 1'b0}));
        check("s2_queue", 32'(exp_q.size()), 32'd0);

        // 3: 16 words while stalled, then a full-rate burst
        do_reset();
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0);
            wr(8'(i));
        end
        repeat (10) cyc(1'b0);
        check("s3_addr", 32'(r_addr), 32'd2);
        check("s3_head", 32'({m_valid, m_data}), 32'({1'b1, 8'h00}));
        check("s3_not_empty", 32'(r_empty), 32'd0);
        p0 = pops;
        repeat (16) cyc(1'b1);
        check("s3_burst", 32'(pops - p0), 32'd16);
        cyc(1'b1);
        check("s3_drained", 32'({m_valid, r_empty}), 32'({1'b0, 1'b1}));
        check("s3_queue", 32'(exp_q.size()), 32'd0);

        // 4: 40 words, random consumer, two pointer wraps
        do_reset();
        p0   = pops;
        n_wr = 0;
        for (int cy = 0; cy < 3000 && (pops - p0) < 40; cy++) begin
            cyc(1'($urandom_range(0, 1)));
            if (n_wr < 40 && !wr_full()) begin
                wr(8'(8'h80 + n_wr));
                n_wr++;
            end
        end
        check("s4_count", 32'(pops - p0), 32'd40);
        check("s4_msb_toggles", 32'(msb_toggles), 32'd2);
        check("s4_rptr", 32'(r_ptr), 32'h0C);
        check("s4_queue", 32'(exp_q.size()), 32'd0);

        // 5: async reset with two words buffered
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0);
            wr(8'(8'hC0 + i));
        end
        repeat (8) cyc(1'b0);
        check("s5_pre", 32'({m_valid, r_addr}), 32'({1'b1, 4'd10}));
        #2;
        r_rst_n = 1'b0;
        #1;
        check("s5_async", 32'({m_valid, r_ptr, r_empty}), 32'({1'b0, 5'd0, 1'b1}));
        do_reset();
        idle_check("s5_idle");

`ifdef FIFO_RD_LEVEL_EN
        // 6: level counts only words still in memory
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0);
            wr(8'(8'h30 + i));
        end
        repeat (10) cyc(1'b0);
        check("s6_level", 32'(r_level), 32'd3);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
